// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/TRAP sequencer selecting the next fetch address.
// Optional misaligned register-jump trapping is enabled by defining PC_GEN_MISALIGN_TRAP_EN.
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        pc_valid,
    output logic        trap,
    output logic [31:0] epc,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] reg_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic        misaligned;

    assign pc_out     = pc;
    assign pc_plus4   = pc + 32'd4;
    assign branch_tgt = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};
    assign fsm_state  = state;

`ifdef PC_GEN_MISALIGN_TRAP_EN
    assign reg_tgt    = reg_target;
    assign misaligned = jump_reg && (reg_target[1:0] != 2'b00);
`else
    // Low target bits are discarded, so a register jump can never misalign.
    logic unused_low_bits;
    assign unused_low_bits = ^reg_target[1:0];
    assign reg_tgt         = {reg_target[31:2], 2'b00};
    assign misaligned      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
            trap     <= 1'b0;
            epc      <= 32'h0000_0000;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (misaligned) begin
                            epc   <= pc;
                            pc    <= TRAP_VECTOR;
                            state <= TRAP;
                            trap  <= 1'b1;
                        end else if (jump_reg) begin
                            pc <= reg_tgt;
                        end else if (jump) begin
                            pc <= jump_tgt;
                        end else if (branch_taken) begin
                            pc <= branch_tgt;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                TRAP: begin
                    // Redirects are ignored; the handler resumes after the vector.
                    if (!stall) begin
                        pc    <= TRAP_VECTOR + 32'd4;
                        state <= RUN;
                        trap  <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc       <= RESET_VECTOR;
                    pc_valid <= 1'b0;
                    trap     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequential, branch, jump, priority, stall, wrap, trap.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        trap;
    logic [31:0] epc;
    logic [1:0]  fsm_state;

    int passed;
    int total;

    pc_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .trap          (trap),
        .epc           (epc),
        .fsm_state     (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jump_reg      = 1'b0;
        reg_target    = 32'h0;
    endtask

    task automatic goto(input logic [31:0] addr);
        clear_inputs();
        jump_reg   = 1'b1;
        reg_target = addr;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        total++;
        if (pc_out !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
        else passed++;
        total++;
        if ({pc_valid, trap} !== 2'b00) $display("FAIL reset_flags: got %b expected %b", {pc_valid, trap}, 2'b00);
        else passed++;
        total++;
        if (epc !== 32'h0) $display("FAIL reset_epc: got %h expected %h", epc, 32'h0);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({pc_valid, pc_out} !== {1'b0, 32'h0}) $display("FAIL boot_invalid: got %b/%h expected 0/00000000", pc_valid, pc_out);
        else passed++;
        tick();
        total++;
        if ({pc_valid, pc_out} !== {1'b1, 32'h0}) $display("FAIL run_first: got %b/%h expected 1/00000000", pc_valid, pc_out);
        else passed++;
    endtask

    task automatic test_sequential();
        tick();
        total++;
        if (pc_out !== 32'h4) $display("FAIL seq_4: got %h expected %h", pc_out, 32'h4);
        else passed++;
        tick();
        total++;
        if (pc_out !== 32'h8) $display("FAIL seq_8: got %h expected %h", pc_out, 32'h8);
        else passed++;
        total++;
        if (pc_plus4 !== 32'hC) $display("FAIL plus4: got %h expected %h", pc_plus4, 32'hC);
        else passed++;
    endtask

    task automatic test_branch();
        goto(32'h100);
        total++;
        if (pc_out !== 32'h100) $display("FAIL goto_100: got %h expected %h", pc_out, 32'h100);
        else passed++;
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        tick();
        total++;
        if (pc_out !== 32'hFC) $display("FAIL branch_back: got %h expected %h", pc_out, 32'hFC);
        else passed++;
        branch_offset = 32'h3;
        tick();
        total++;
        if (pc_out !== 32'h10C) $display("FAIL branch_fwd: got %h expected %h", pc_out, 32'h10C);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_jump();
        goto(32'h1000_0000);
        jump       = 1'b1;
        jump_index = 26'h0000040;
        tick();
        total++;
        if (pc_out !== 32'h1000_0100) $display("FAIL jump_abs: got %h expected %h", pc_out, 32'h1000_0100);
        else passed++;
        total++;
        if (pc_plus4 !== 32'h1000_0104) $display("FAIL jump_plus4: got %h expected %h", pc_plus4, 32'h1000_0104);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_priority();
        goto(32'h20);
        jump_reg      = 1'b1;
        reg_target    = 32'h400;
        jump          = 1'b1;
        jump_index    = 26'h3FF;
        branch_taken  = 1'b1;
        branch_offset = 32'h5;
        stall         = 1'b1;
        tick();
        total++;
        if (pc_out !== 32'h20) $display("FAIL stall_hold: got %h expected %h", pc_out, 32'h20);
        else passed++;
        stall = 1'b0;
        tick();
        total++;
        if (pc_out !== 32'h400) $display("FAIL prio_jr: got %h expected %h", pc_out, 32'h400);
        else passed++;
        goto(32'h20);
        jump          = 1'b1;
        jump_index    = 26'h10;
        branch_taken  = 1'b1;
        branch_offset = 32'h5;
        tick();
        total++;
        if (pc_out !== 32'h40) $display("FAIL prio_j: got %h expected %h", pc_out, 32'h40);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_misalign();
        goto(32'h20);
        jump_reg   = 1'b1;
        reg_target = 32'h402;
        tick();
        clear_inputs();
`ifdef PC_GEN_MISALIGN_TRAP_EN
        total++;
        if ({trap, pc_out, epc} !== {1'b1, 32'h180, 32'h20}) $display("FAIL trap_entry: got %b/%h/%h expected 1/00000180/00000020", trap, pc_out, epc);
        else passed++;
        stall = 1'b1;
        jump  = 1'b1;
        tick();
        total++;
        if ({trap, pc_out} !== {1'b1, 32'h180}) $display("FAIL trap_stall: got %b/%h expected 1/00000180", trap, pc_out);
        else passed++;
        stall = 1'b0;
        tick();
        total++;
        if ({trap, pc_out} !== {1'b0, 32'h184}) $display("FAIL trap_exit: got %b/%h expected 0/00000184", trap, pc_out);
        else passed++;
        clear_inputs();
`else
        total++;
        if ({trap, pc_out, epc} !== {1'b0, 32'h400, 32'h0}) $display("FAIL jr_forced_align: got %b/%h/%h expected 0/00000400/00000000", trap, pc_out, epc);
        else passed++;
`endif
    endtask

    task automatic test_wrap();
        goto(32'hFFFF_FFFC);
        total++;
        if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0);
        else passed++;
        tick();
        total++;
        if (pc_out !== 32'h0) $display("FAIL wrap_seq: got %h expected %h", pc_out, 32'h0);
        else passed++;
    endtask

    task automatic test_reset_mid();
`ifdef PC_GEN_MISALIGN_TRAP_EN
        goto(32'h30);
        jump_reg   = 1'b1;
        reg_target = 32'h401;
        tick();
        stall = 1'b1;
`else
        goto(32'h30);
        jump_reg   = 1'b1;
        reg_target = 32'h500;
        stall      = 1'b1;
        tick();
`endif
        rst_n = 1'b0;
        #2;
        total++;
        if ({pc_out, trap, pc_valid} !== {32'h0, 1'b0, 1'b0}) $display("FAIL reset_async: got %h/%b/%b expected 00000000/0/0", pc_out, trap, pc_valid);
        else passed++;
        total++;
        if (fsm_state !== 2'd0) $display("FAIL reset_state: got %0d expected %0d", fsm_state, 0);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if ({pc_valid, pc_out, fsm_state} !== {1'b1, 32'h0, 2'd1}) $display("FAIL boot_under_stall: got %b/%h/%0d expected 1/00000000/1", pc_valid, pc_out, fsm_state);
        else passed++;
        tick();
        total++;
        if (pc_out !== 32'h0) $display("FAIL post_reset_stall: got %h expected %h", pc_out, 32'h0);
        else passed++;
        clear_inputs();
        tick();
        total++;
        if (pc_out !== 32'h4) $display("FAIL post_reset_seq: got %h expected %h", pc_out, 32'h4);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_priority();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0180, is the fetch address on a misaligned-target trap.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold the current PC and state this cycle.
REQ-006 branch_taken  input  1  conditional branch resolved taken.
REQ-007 branch_offset  input  32  sign-extended word offset of the branch.
REQ-008 jump  input  1  absolute jump (J/JAL).
REQ-009 jump_index  input  26  jump instruction index field.
REQ-010 jump_reg  input  1  register-indirect jump (JR/JALR).
REQ-011 reg_target  input  32  register jump target.
REQ-012 pc_out  output  32  current fetch address; feeds the PC/instruction-memory path.
REQ-013 pc_plus4  output  32  pc_out + 4 (link value); combinational from pc_out.
REQ-014 pc_valid  output  1  pc_out is a valid fetch address.
REQ-015 trap  output  1  misaligned-target trap is active this cycle.
REQ-016 epc  output  32  address of the instruction that caused the last trap.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN and TRAP.
REQ-018 BOOT: pc_out = RESET_VECTOR, pc_valid = 0; next edge -> RUN with the PC unchanged, regardless of stall.
REQ-019 RUN with stall = 1: PC, state and epc hold; all redirect inputs are ignored (stall wins over every redirect).
REQ-020 RUN, no stall: next PC priority is jump_reg > jump > branch_taken > sequential.
REQ-021 Sequential target: pc_plus4.
REQ-022 Branch target: pc_plus4 + (branch_offset << 2), modulo 2^32.
REQ-023 Jump target: {pc_plus4[31:28], jump_index, 2'b00}.
REQ-024 Register target: reg_target.
REQ-025 All additions SHALL wrap modulo 2^32 with no flag; 32'hFFFF_FFFC sequential -> 32'h0000_0000.
REQ-026 Redirects take effect on the edge they are sampled, with a latency of one cycle to pc_out.
REQ-027 pc_valid = 1 in RUN and TRAP.
REQ-028 TRAP (entry: see REQ-035): pc_out = TRAP_VECTOR, trap = 1; redirect inputs are ignored.
REQ-029 TRAP exit: the next non-stalled edge sets PC to TRAP_VECTOR + 4 and enters RUN; under stall the block holds in TRAP with trap = 1.

Reset
REQ-030 While rst_n = 0: state = BOOT, pc_out = RESET_VECTOR, pc_valid = 0, trap = 0, epc = 0, effective immediately without a clock.
REQ-031 Reset asserted in any state, mid-stall or mid-trap, SHALL abort the operation; no pending redirect survives reset.
REQ-032 After rst_n deasserts, the first rising edge leaves BOOT (REQ-018).

Configuration
REQ-033 The macro PC_GEN_MISALIGN_TRAP_EN SHALL control misaligned-target trapping.
REQ-034 Without the macro, reg_target[1:0] is forced to 2'b00, trap is tied 0, epc is tied 0, and TRAP is unreachable.
REQ-035 With the macro, a RUN-state non-stalled jump_reg with reg_target[1:0] != 0 SHALL load epc <= pc_out, PC <= TRAP_VECTOR and enter TRAP instead of taking the jump.

Verification
REQ-036 Reset release, no redirects -> pc_valid 0 for one cycle at 0x0, then pc_out 0x0, 0x4, 0x8 on successive edges.
REQ-037 At pc 0x100: branch_taken = 1, offset 32'hFFFF_FFFE -> next pc_out 0xFC; jump index 0x0000040 at pc 0x1000_0000 -> 0x1000_0100.
REQ-038 At pc 0x20, jump_reg, jump and branch_taken asserted together, reg_target 0x400 -> 0x400; with stall = 1 in the same cycle -> pc holds at 0x20.
REQ-039 At pc 0x20, jump_reg = 1, reg_target 0x402, macro defined -> trap = 1, pc_out 0x180, epc 0x20; next edge -> 0x184.
REQ-040 Same stimulus as REQ-039, macro undefined -> pc_out 0x400, trap 0. Separately, pc 0xFFFF_FFFC sequential -> 0x0; rst_n pulsed low mid-TRAP -> immediate pc_out 0x0, trap 0, pc_valid 0.
